// File: rtl/coin_dispenser_if.sv
// Coin dispenser bus: dispense request with coin counts, the per-coin
// eject/ack handshake with the ejector, and status back to the controller.
// The master side is the environment (vending controller plus ejector);
// the slave side is the dispenser itself.
interface coin_dispenser_if;
    logic       start;
    logic [3:0] quarters_in;
    logic [3:0] dimes_in;
    logic [3:0] nickels_in;
    logic [3:0] pennies_in;
    logic       eject_ack;
    logic       eject_q;
    logic       eject_d;
    logic       eject_n;
    logic       eject_p;
    logic       busy;
    logic       done;
    logic       fault;
    logic [9:0] dispensed;

    modport master (
        output start, quarters_in, dimes_in, nickels_in, pennies_in, eject_ack,
        input  eject_q, eject_d, eject_n, eject_p, busy, done, fault, dispensed
    );

    modport slave (
        input  start, quarters_in, dimes_in, nickels_in, pennies_in, eject_ack,
        output eject_q, eject_d, eject_n, eject_p, busy, done, fault, dispensed
    );
endinterface

// File: rtl/coin_dispenser.sv
// Coin dispenser: ejects a latched set of coins one at a time (quarters,
// dimes, nickels, pennies), waits for an ack per coin, spaces coins by a
// fixed gap, and raises a sticky fault if an ack never arrives.
module coin_dispenser #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input logic             clk,
    input logic             reset,
    coin_dispenser_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_GAP,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        C_Q,
        C_D,
        C_N,
        C_P
    } coin_t;

    // Last timeout count value before the fault fires; eject stays high TIMEOUT cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    // Last gap count value; unused when GAP_CYCLES is 0 (GAP is skipped).
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t     state;
    coin_t      coin;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] cnt_n;
    logic [3:0] cnt_p;
    logic [7:0] gap_cnt;
    logic [7:0] tmo_cnt;

    logic       eject_q_r;
    logic       eject_d_r;
    logic       eject_n_r;
    logic       eject_p_r;
    logic       busy_r;
    logic       done_r;
    logic       fault_r;
    logic [9:0] dispensed_r;

    function automatic logic [9:0] coin_value(input coin_t c);
        case (c)
            C_Q:     return 10'd25;
            C_D:     return 10'd10;
            C_N:     return 10'd5;
            default: return 10'd1;
        endcase
    endfunction

    assign bus.eject_q   = eject_q_r;
    assign bus.eject_d   = eject_d_r;
    assign bus.eject_n   = eject_n_r;
    assign bus.eject_p   = eject_p_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.fault     = fault_r;
    assign bus.dispensed = dispensed_r;

    // Dispense sequencer: all state and outputs registered, async reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            coin        <= C_Q;
            cnt_q       <= 4'd0;
            cnt_d       <= 4'd0;
            cnt_n       <= 4'd0;
            cnt_p       <= 4'd0;
            gap_cnt     <= 8'd0;
            tmo_cnt     <= 8'd0;
            eject_q_r   <= 1'b0;
            eject_d_r   <= 1'b0;
            eject_n_r   <= 1'b0;
            eject_p_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
            dispensed_r <= 10'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                // IDLE and FAULT both accept a new request; FAULT keeps fault high until then.
                S_IDLE, S_FAULT: begin
                    if (bus.start) begin
                        cnt_q       <= bus.quarters_in;
                        cnt_d       <= bus.dimes_in;
                        cnt_n       <= bus.nickels_in;
                        cnt_p       <= bus.pennies_in;
                        dispensed_r <= 10'd0;
                        fault_r     <= 1'b0;
                        busy_r      <= 1'b1;
                        state       <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    tmo_cnt <= 8'd0;
                    if (cnt_q != 4'd0) begin
                        coin      <= C_Q;
                        eject_q_r <= 1'b1;
                        state     <= S_EJECT;
                    end else if (cnt_d != 4'd0) begin
                        coin      <= C_D;
                        eject_d_r <= 1'b1;
                        state     <= S_EJECT;
                    end else if (cnt_n != 4'd0) begin
                        coin      <= C_N;
                        eject_n_r <= 1'b1;
                        state     <= S_EJECT;
                    end else if (cnt_p != 4'd0) begin
                        coin      <= C_P;
                        eject_p_r <= 1'b1;
                        state     <= S_EJECT;
                    end else begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                // Ack is checked before the timeout so an ack on the last cycle still counts.
                S_EJECT: begin
                    if (bus.eject_ack) begin
                        case (coin)
                            C_Q:     cnt_q <= cnt_q - 4'd1;
                            C_D:     cnt_d <= cnt_d - 4'd1;
                            C_N:     cnt_n <= cnt_n - 4'd1;
                            default: cnt_p <= cnt_p - 4'd1;
                        endcase
                        dispensed_r <= dispensed_r + coin_value(coin);
                        eject_q_r   <= 1'b0;
                        eject_d_r   <= 1'b0;
                        eject_n_r   <= 1'b0;
                        eject_p_r   <= 1'b0;
                        gap_cnt     <= 8'd0;
                        if (GAP_CYCLES == 0) begin
                            state <= S_SELECT;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        eject_q_r <= 1'b0;
                        eject_d_r <= 1'b0;
                        eject_n_r <= 1'b0;
                        eject_p_r <= 1'b0;
                        fault_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        state     <= S_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_SELECT;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_dispenser.sv
// Directed bench for coin_dispenser: a default-parameter instance for the
// sequencing, timeout, ignored-start and reset cases, and a GAP_CYCLES=0
// instance for the maximum load.
module tb_coin_dispenser;

    logic clk;
    logic rst_a;
    logic rst_b;

    coin_dispenser_if ifa ();
    coin_dispenser_if ifb ();

    coin_dispenser #(.GAP_CYCLES(2), .TIMEOUT(255)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    coin_dispenser #(.GAP_CYCLES(0), .TIMEOUT(255)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;

    // Results gathered by serve()
    int         n_ej;
    int         ej_code;
    int         order_err;
    int         onehot_err;
    int         ndone;
    int         min_gap;
    int         cnt_type [4];
    logic       busy_at_done;
    logic [9:0] steps [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ejects(input int which);
        if (which != 0) return {ifb.eject_p, ifb.eject_n, ifb.eject_d, ifb.eject_q};
        return {ifa.eject_p, ifa.eject_n, ifa.eject_d, ifa.eject_q};
    endfunction

    function automatic int disp(input int which);
        if (which != 0) return 32'(ifb.dispensed);
        return 32'(ifa.dispensed);
    endfunction

    function automatic logic sig_done(input int which);
        if (which != 0) return ifb.done;
        return ifa.done;
    endfunction

    function automatic logic sig_busy(input int which);
        if (which != 0) return ifb.busy;
        return ifa.busy;
    endfunction

    task automatic set_ack(input int which, input logic v);
        if (which != 0) ifb.eject_ack = v;
        else ifa.eject_ack = v;
    endtask

    task automatic start_dut(input int which, input logic [3:0] q, input logic [3:0] d,
                             input logic [3:0] n, input logic [3:0] p);
        if (which != 0) begin
            ifb.quarters_in = q; ifb.dimes_in = d; ifb.nickels_in = n; ifb.pennies_in = p;
            ifb.start = 1'b1;
            tick();
            ifb.start = 1'b0;
        end else begin
            ifa.quarters_in = q; ifa.dimes_in = d; ifa.nickels_in = n; ifa.pennies_in = p;
            ifa.start = 1'b1;
            tick();
            ifa.start = 1'b0;
        end
    endtask

    // Acts as the ejector: acks every eject one cycle after it appears and logs what happened.
    task automatic serve(input int which, input int cycles);
        logic [3:0] ej;
        logic       prev_ack;
        int         low_run;
        int         last_type;
        int         t;
        n_ej = 0; ej_code = 0; order_err = 0; onehot_err = 0; ndone = 0;
        min_gap = 1000; busy_at_done = 1'b1; steps.delete();
        for (int i = 0; i < 4; i++) cnt_type[i] = 0;
        prev_ack = 1'b0; low_run = 0; last_type = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            ej = ejects(which);
            if (prev_ack) steps.push_back(10'(disp(which)));
            if ($countones(ej) > 1) onehot_err++;
            if (sig_done(which)) begin
                ndone++;
                busy_at_done = sig_busy(which);
            end
            if (ej != 4'd0) begin
                t = ej[0] ? 1 : ej[1] ? 2 : ej[2] ? 3 : 4;
                if (n_ej > 0 && low_run < min_gap) min_gap = low_run;
                if (t < last_type) order_err++;
                last_type = t;
                n_ej++;
                ej_code = (ej_code << 4) | t;
                cnt_type[t-1]++;
                low_run = 0;
                set_ack(which, 1'b1);
                prev_ack = 1'b1;
            end else begin
                low_run++;
                set_ack(which, 1'b0);
                prev_ack = 1'b0;
            end
        end
        set_ack(which, 1'b0);
    endtask

    initial begin
        int exp_steps [6];
        int high_cnt;
        int guard;
        exp_steps = '{25, 50, 60, 61, 62, 63};
        n_chk = 0;
        n_pass = 0;
        ifa.start = 1'b0; ifa.eject_ack = 1'b0;
        ifa.quarters_in = 4'd0; ifa.dimes_in = 4'd0; ifa.nickels_in = 4'd0; ifa.pennies_in = 4'd0;
        ifb.start = 1'b0; ifb.eject_ack = 1'b0;
        ifb.quarters_in = 4'd0; ifb.dimes_in = 4'd0; ifb.nickels_in = 4'd0; ifb.pennies_in = 4'd0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // Reset state
        chk("rst_eject", 32'(ejects(0)), 0);
        chk("rst_busy", 32'(ifa.busy), 0);
        chk("rst_done", 32'(ifa.done), 0);
        chk("rst_fault", 32'(ifa.fault), 0);
        chk("rst_disp", disp(0), 0);

        // Q=2 D=1 N=0 P=3 with prompt acks
        start_dut(0, 4'd2, 4'd1, 4'd0, 4'd3);
        chk("t1_busy_after_start", 32'(ifa.busy), 1);
        chk("t1_no_eject_in_select", 32'(ejects(0)), 0);
        serve(0, 40);
        chk("t1_seq", ej_code, 32'h112444);
        chk("t1_onehot", onehot_err, 0);
        chk("t1_gap_ok", (min_gap >= 2) ? 1 : 0, 1);
        chk("t1_nsteps", steps.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t1_step%0d", i), (i < steps.size()) ? 32'(steps[i]) : -1, exp_steps[i]);
        chk("t1_ndone", ndone, 1);
        chk("t1_busy_at_done", 32'(busy_at_done), 0);
        chk("t1_busy_end", 32'(ifa.busy), 0);

        // All-zero request: done one edge after the start edge, nothing ejected
        start_dut(0, 4'd0, 4'd0, 4'd0, 4'd0);
        chk("t2_done_early", 32'(ifa.done), 0);
        tick();
        chk("t2_done", 32'(ifa.done), 1);
        chk("t2_busy", 32'(ifa.busy), 0);
        chk("t2_eject", 32'(ejects(0)), 0);
        chk("t2_disp", disp(0), 0);
        tick();
        chk("t2_done_one_cycle", 32'(ifa.done), 0);

        // Timeout: Q=1 never acked
        start_dut(0, 4'd1, 4'd0, 4'd0, 4'd0);
        tick();
        high_cnt = ifa.eject_q ? 1 : 0;
        guard = 0;
        while (ifa.eject_q && guard < 400) begin
            tick();
            guard++;
            if (ifa.eject_q) high_cnt++;
        end
        chk("t3_eject_high_cycles", high_cnt, 255);
        chk("t3_fault", 32'(ifa.fault), 1);
        chk("t3_busy", 32'(ifa.busy), 0);
        chk("t3_disp", disp(0), 0);
        ifa.eject_ack = 1'b1;
        tick();
        ifa.eject_ack = 1'b0;
        tick();
        chk("t3_fault_sticky", 32'(ifa.fault), 1);
        chk("t3_stray_ack_disp", disp(0), 0);
        start_dut(0, 4'd0, 4'd0, 4'd0, 4'd1);
        chk("t3_fault_cleared", 32'(ifa.fault), 0);
        chk("t3_busy_restart", 32'(ifa.busy), 1);
        serve(0, 15);
        chk("t3_penny_seq", ej_code, 4);
        chk("t3_penny_disp", disp(0), 1);
        chk("t3_penny_done", ndone, 1);

        // Start while busy is ignored
        start_dut(0, 4'd3, 4'd0, 4'd0, 4'd0);
        ifa.quarters_in = 4'd0;
        ifa.pennies_in = 4'd5;
        ifa.start = 1'b1;
        tick();
        tick();
        ifa.start = 1'b0;
        serve(0, 40);
        chk("t4_nej", n_ej, 3);
        chk("t4_seq", ej_code, 32'h111);
        chk("t4_no_pennies", cnt_type[3], 0);
        chk("t4_disp", disp(0), 75);
        chk("t4_ndone", ndone, 1);

        // Async reset while eject_d high
        start_dut(0, 4'd0, 4'd2, 4'd0, 4'd0);
        tick();
        chk("t5_eject_d_high", 32'(ifa.eject_d), 1);
        rst_a = 1'b1;
        #1;
        chk("t5_eject_d_async_drop", 32'(ifa.eject_d), 0);
        chk("t5_busy", 32'(ifa.busy), 0);
        chk("t5_fault", 32'(ifa.fault), 0);
        chk("t5_disp", disp(0), 0);
        tick();
        rst_a = 1'b0;
        chk("t5_done", 32'(ifa.done), 0);
        ifa.eject_ack = 1'b1;
        tick();
        ifa.eject_ack = 1'b0;
        tick();
        chk("t5_stray_ack_disp", disp(0), 0);
        chk("t5_stray_ack_eject", 32'(ejects(0)), 0);
        chk("t5_stray_ack_busy", 32'(ifa.busy), 0);

        // Max load on the zero-gap instance
        start_dut(1, 4'd15, 4'd15, 4'd15, 4'd15);
        serve(1, 160);
        chk("t6_nej", n_ej, 60);
        chk("t6_nq", cnt_type[0], 15);
        chk("t6_nd", cnt_type[1], 15);
        chk("t6_nn", cnt_type[2], 15);
        chk("t6_np", cnt_type[3], 15);
        chk("t6_order", order_err, 0);
        chk("t6_onehot", onehot_err, 0);
        chk("t6_disp", disp(1), 615);
        chk("t6_ndone", ndone, 1);
        chk("t6_busy_at_done", 32'(busy_at_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/coin_dispenser.md
Name: coin_dispenser

Overview:
- Consumes the coin-count vector produced by the change-making stage (quarters/dimes/nickels/pennies, 4 bits each).
- Drives the physical coin ejector one coin at a time, in the order quarters, then dimes, then nickels, then pennies.
- Uses a per-coin eject/ack handshake, an inter-coin gap and a timeout fault.
- Reports the running cents total dispensed and a completion pulse back to the vending controller.

Parameters:
- GAP_CYCLES, 2, idle cycles between an ack and the next coin selection. 0 is legal and means no GAP state.
- TIMEOUT, 255, maximum cycles an eject line stays high awaiting ack before a fault is raised. Must be ≥1; the counter is 8 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  request to dispense; sampled only in IDLE and FAULT.
- quarters_in  input  4  quarters to dispense, latched on accepted start.
- dimes_in  input  4  dimes to dispense, latched on accepted start.
- nickels_in  input  4  nickels to dispense, latched on accepted start.
- pennies_in  input  4  pennies to dispense, latched on accepted start.
- eject_ack  input  1  ejector confirms one coin released.
- eject_q  output  1  eject one quarter (level, held until ack).
- eject_d  output  1  eject one dime.
- eject_n  output  1  eject one nickel.
- eject_p  output  1  eject one penny.
- busy  output  1  high in SELECT, EJECT and GAP.
- done  output  1  one-cycle pulse on completion.
- fault  output  1  ack timeout occurred; sticky.
- dispensed  output  10  cents dispensed since last accepted start.

Behaviour:
- Reset (async, active-high): state IDLE; all eject_* 0; busy 0; done 0; fault 0; dispensed 0; internal counts 0; gap and timeout counters 0.
- All outputs are registered. At most one eject_* is high at any time.
- States: IDLE, SELECT, EJECT, GAP, FAULT.
- IDLE, start=1 at an edge:
  - Latch all four counts; clear dispensed and fault; go to SELECT; busy=1 after that edge.
- SELECT:
  - Pick the first nonzero count in priority order Q, D, N, P.
  - Go to EJECT with the matching eject_* = 1 after the next edge. First eject is therefore high 2 cycles after the start edge.
  - Clear the timeout counter.
  - If all counts are 0: done=1 for exactly one cycle, busy=0, go to IDLE. Start with all-zero inputs therefore gives done 2 edges after start and no eject.
- EJECT:
  - eject_* held high.
  - On an edge with eject_ack=1:
    - decrement that count;
    - add the coin value (25/10/5/1) to dispensed;
    - deassert eject_*;
    - go to GAP, or straight to SELECT if GAP_CYCLES=0.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no ack: deassert eject_*, fault=1, busy=0, go to FAULT. Counts and dispensed are frozen.
- GAP: count GAP_CYCLES edges, then go to SELECT. eject_ack is ignored.
- FAULT:
  - fault stays 1; outputs otherwise idle.
  - start=1 behaves as in IDLE: clears fault, latches new counts, goes to SELECT.
  - Only reset or an accepted start leaves FAULT.
- start while busy: ignored; latched counts unchanged.
- eject_ack outside EJECT: ignored, with no count or dispensed change.
- Ack and timeout on the same edge: ack wins.
- Width: dispensed is a 10-bit unsigned value. The maximum is 15·(25+10+5+1)=615, so it never wraps. Counts never underflow, because only nonzero counts are selected.
- Reset asserted mid-dispense: the eject line drops immediately (async); all state is cleared; no done pulse.

Test Plan:
- Reset release, start with Q=2, D=1, N=0, P=3, ack 1 cycle after each eject -> eject sequence q,q,d,p,p,p; each eject is separated by ≥GAP_CYCLES low cycles; dispensed steps 25,50,60,61,62,63; a single done pulse; busy falls with done.
- Start with all counts 0 -> done pulse 2 edges after start, no eject_* high, dispensed=0.
- Start with Q=1 and eject_ack never asserted -> eject_q high for exactly TIMEOUT cycles, then fault=1, busy=0, dispensed=0. A new start with P=1 then clears fault and ejects one penny, giving dispensed=1.
- Mid-run (Q=3 in progress), pulse start with P=5 -> ignored; the run completes with dispensed=75 and no pennies ejected.
- Assert reset while eject_d is high -> eject_d drops without waiting for clk; all outputs return to 0; a stray eject_ack afterwards has no effect.
- Max load Q=D=N=P=15, GAP_CYCLES=0 -> 60 ejects in priority order, dispensed=615, no wrap, done pulse once.
